// File: rtl/conv_dnn_bridge_if.sv
// ---------------------------------------------------------------------------
// conv_dnn_bridge_if
// Bundles the data/handshake signals between the conv pipeline, the
// conv_dnn_bridge and the dense network.
//   slave  modport : used by the bridge (takes conv data and dnn_ready, drives
//                    the DNN side, out_ready and busy)
//   master modport : used by whatever drives the bridge (stimulus side)
// Signals:
//   in_valid[NumK], in_data[NumPE][BitSize], in_set_done, dnn_ready
//   out_ready, out_valid[NumK], out_data[NumPE][BitSize], out_set_done,
//   out_fl_res, busy
// Optional (macro BRIDGE_STATUS_EN): sets_done[8], err
// ---------------------------------------------------------------------------
interface conv_dnn_bridge_if #(
    parameter int BitSize = 32,
    parameter int NumPE   = 2,
    parameter int NumK    = 4
);
    logic [NumK-1:0]               in_valid;
    logic [NumPE-1:0][BitSize-1:0] in_data;
    logic                          in_set_done;
    logic                          dnn_ready;
    logic                          out_ready;
    logic [NumK-1:0]               out_valid;
    logic [NumPE-1:0][BitSize-1:0] out_data;
    logic                          out_set_done;
    logic                          out_fl_res;
    logic                          busy;
`ifdef BRIDGE_STATUS_EN
    logic [7:0]                    sets_done;
    logic                          err;
`endif

    modport slave (
        input  in_valid, in_data, in_set_done, dnn_ready,
        output out_ready, out_valid, out_data, out_set_done, out_fl_res, busy
`ifdef BRIDGE_STATUS_EN
        , output sets_done, err
`endif
    );

    modport master (
        output in_valid, in_data, in_set_done, dnn_ready,
        input  out_ready, out_valid, out_data, out_set_done, out_fl_res, busy
`ifdef BRIDGE_STATUS_EN
        , input sets_done, err
`endif
    );
endinterface

// File: rtl/conv_dnn_bridge.sv
// ---------------------------------------------------------------------------
// conv_dnn_bridge
// Handoff stage between the conv/pooling pipeline and the dense network.
// Valid vector, PE data and set-done travel through PipeStages register
// stages (valid optionally bit-reversed on entry). Once a set-done leaves the
// pipeline a flush FSM waits FlushDelay cycles, drives a FlushLen-cycle
// out_fl_res pulse, holds GuardCycles more cycles, and keeps the conv side
// stalled (out_ready low) during FLUSH and GUARD.
// Ports:
//   clk  - clock
//   res  - asynchronous active-high reset
//   bus  - conv_dnn_bridge_if.slave (data/handshake towards conv and DNN)
// Optional feature macro: BRIDGE_STATUS_EN adds bus.sets_done (saturating
// count of finished flush sequences) and bus.err (sticky protocol error).
// ---------------------------------------------------------------------------
module conv_dnn_bridge #(
    parameter int BitSize      = 32,
    parameter int NumPE        = 2,
    parameter int NumK         = 4,
    parameter int PipeStages   = 1,
    parameter int FlushDelay   = 10,
    parameter int FlushLen     = 1,
    parameter int GuardCycles  = 2,
    parameter int ReverseValid = 1
) (
    input  logic              clk,
    input  logic              res,
    conv_dnn_bridge_if.slave  bus
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // One extra bit of headroom so the counter can never wrap before the
    // terminal compare fires.
    localparam int CntW = $clog2(max3(FlushDelay, FlushLen, GuardCycles) + 1) + 1;
    localparam int DataW = NumPE * BitSize;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLUSH = 2'd2,
        GUARD = 2'd3
    } state_t;

    function automatic logic [NumK-1:0] order_valid(input logic [NumK-1:0] v);
        logic [NumK-1:0] r;
        r = v;
        if (ReverseValid != 0) begin
            for (int i = 0; i < NumK; i++) begin
                r[i] = v[NumK-1-i];
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [CntW-1:0]     cnt_r;
    logic [CntW-1:0]     cnt_next_s;
    logic                fl_res_r;
    logic                busy_r;
    logic                ready_s;
    logic [NumK-1:0]     stage_valid_s;
    logic                stage_sd_s;
    logic                set_done_out_s;

    logic [NumK-1:0]     valid_pipe_r [PipeStages];
    logic [DataW-1:0]    data_pipe_r  [PipeStages];
    logic [PipeStages-1:0] sd_pipe_r;

    // Conv side may only issue while the DNN is ready and no flush is pending.
    assign ready_s        = bus.dnn_ready & ((state_r == IDLE) | (state_r == COUNT));
    assign bus.out_ready  = ready_s;
    assign set_done_out_s = sd_pipe_r[PipeStages-1];

    // Stage-1 inputs: beats offered while stalled are dropped (data still captured).
    always_comb begin
        stage_valid_s = {NumK{1'b0}};
        stage_sd_s    = 1'b0;
        if (ready_s) begin
            stage_valid_s = order_valid(bus.in_valid);
            stage_sd_s    = bus.in_set_done;
        end else begin
            stage_valid_s = {NumK{1'b0}};
            stage_sd_s    = 1'b0;
        end
    end

    // Delay line for valid/data/set-done; keeps shifting during FLUSH/GUARD.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < PipeStages; i++) begin
                valid_pipe_r[i] <= {NumK{1'b0}};
                data_pipe_r[i]  <= {DataW{1'b0}};
            end
            sd_pipe_r <= {PipeStages{1'b0}};
        end else begin
            valid_pipe_r[0] <= stage_valid_s;
            data_pipe_r[0]  <= bus.in_data;
            sd_pipe_r[0]    <= stage_sd_s;
            for (int i = 1; i < PipeStages; i++) begin
                valid_pipe_r[i] <= valid_pipe_r[i-1];
                data_pipe_r[i]  <= data_pipe_r[i-1];
                sd_pipe_r[i]    <= sd_pipe_r[i-1];
            end
        end
    end

    assign bus.out_valid    = valid_pipe_r[PipeStages-1];
    assign bus.out_data     = data_pipe_r[PipeStages-1];
    assign bus.out_set_done = set_done_out_s;

    // Flush FSM next-state and counter; cnt restarts at 1 on every state entry.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (set_done_out_s) begin
                    if (FlushDelay == 0) begin
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = COUNT;
                    end
                    cnt_next_s = CntW'(1'b1);
                end else begin
                    cnt_next_s = {CntW{1'b0}};
                end
            end
            COUNT: begin
                if (cnt_r == CntW'(FlushDelay)) begin
                    state_next_s = FLUSH;
                    cnt_next_s   = CntW'(1'b1);
                end else begin
                    cnt_next_s = cnt_r + CntW'(1'b1);
                end
            end
            FLUSH: begin
                if (cnt_r == CntW'(FlushLen)) begin
                    if (GuardCycles == 0) begin
                        state_next_s = IDLE;
                        cnt_next_s   = {CntW{1'b0}};
                    end else begin
                        state_next_s = GUARD;
                        cnt_next_s   = CntW'(1'b1);
                    end
                end else begin
                    cnt_next_s = cnt_r + CntW'(1'b1);
                end
            end
            GUARD: begin
                if (cnt_r == CntW'(GuardCycles)) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CntW{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + CntW'(1'b1);
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CntW{1'b0}};
            end
        endcase
    end

    // FSM state, counter and registered pulse/busy outputs (decoded from next state).
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r  <= IDLE;
            cnt_r    <= {CntW{1'b0}};
            fl_res_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            fl_res_r <= (state_next_s == FLUSH);
            busy_r   <= (state_next_s != IDLE);
        end
    end

    assign bus.out_fl_res = fl_res_r;
    assign bus.busy       = busy_r;

`ifdef BRIDGE_STATUS_EN
    logic [7:0] sets_done_r;
    logic       err_r;
    logic       err_event_s;
    logic       flush_exit_s;

    assign flush_exit_s = (state_r == FLUSH) & (state_next_s != FLUSH);
    assign err_event_s  = (((|bus.in_valid) | bus.in_set_done) & ~ready_s)
                        | (set_done_out_s & (state_r != IDLE));

    // Saturating completed-flush counter and sticky error flag.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sets_done_r <= 8'd0;
            err_r       <= 1'b0;
        end else begin
            if (flush_exit_s && (sets_done_r != 8'hFF)) begin
                sets_done_r <= sets_done_r + 8'd1;
            end else begin
                sets_done_r <= sets_done_r;
            end
            err_r <= err_r | err_event_s;
        end
    end

    assign bus.sets_done = sets_done_r;
    assign bus.err       = err_r;
`endif

endmodule

// File: tb/tb_conv_dnn_bridge.sv
// ---------------------------------------------------------------------------
// tb_conv_dnn_bridge
// Two bridges: dut_a with default parameters (reversed valid, FlushDelay 10,
// FlushLen 1, GuardCycles 2) and dut_b in pass-through order with
// FlushDelay 0, FlushLen 3, GuardCycles 0. A negedge scoreboard predicts
// each output beat from the inputs and the expected stall windows; directed
// sequences check flush pulse, busy and reset timing cycle by cycle.
// ---------------------------------------------------------------------------
module tb_conv_dnn_bridge;

    localparam int PS = 1;

    typedef struct packed {
        logic [3:0]  v;
        logic [63:0] d;
        logic        sd;
    } beat_t;

    logic clk;
    logic res;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   blk_a_lo = -100;
    int   blk_a_hi = -100;
    int   blk_b_lo = -100;
    int   blk_b_hi = -100;
    int   pulses_a = 0;
    int   pulses_b = 0;
    logic fl_prev_a = 1'b0;
    logic fl_prev_b = 1'b0;
    beat_t qa[$];
    beat_t qb[$];

    conv_dnn_bridge_if #(.BitSize(32), .NumPE(2), .NumK(4)) ifa ();
    conv_dnn_bridge_if #(.BitSize(32), .NumPE(2), .NumK(4)) ifb ();

    conv_dnn_bridge dut_a (
        .clk (clk),
        .res (res),
        .bus (ifa)
    );

    conv_dnn_bridge #(
        .PipeStages   (1),
        .FlushDelay   (0),
        .FlushLen     (3),
        .GuardCycles  (0),
        .ReverseValid (0)
    ) dut_b (
        .clk (clk),
        .res (res),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Scoreboard: compare the beat predicted one pipeline depth ago, then
    // predict the beat being offered now.
    always @(negedge clk) begin : scoreboard
        beat_t e;
        logic  rdy;
        if (res) begin
            qa.delete();
            qb.delete();
        end else begin
            rdy = ifa.dnn_ready && !(cyc >= blk_a_lo && cyc <= blk_a_hi);
            check_val("a_out_ready", 64'(ifa.out_ready), 64'(rdy));
            if (qa.size() >= PS) begin
                e = qa.pop_front();
                check_val("a_out_valid", 64'(ifa.out_valid), 64'(e.v));
                check_val("a_out_data", 64'(ifa.out_data), e.d);
                check_val("a_out_set_done", 64'(ifa.out_set_done), 64'(e.sd));
            end
            e.v  = rdy ? rev4(ifa.in_valid) : 4'h0;
            e.d  = 64'(ifa.in_data);
            e.sd = rdy & ifa.in_set_done;
            qa.push_back(e);

            rdy = ifb.dnn_ready && !(cyc >= blk_b_lo && cyc <= blk_b_hi);
            check_val("b_out_ready", 64'(ifb.out_ready), 64'(rdy));
            if (qb.size() >= PS) begin
                e = qb.pop_front();
                check_val("b_out_valid", 64'(ifb.out_valid), 64'(e.v));
                check_val("b_out_data", 64'(ifb.out_data), e.d);
                check_val("b_out_set_done", 64'(ifb.out_set_done), 64'(e.sd));
            end
            e.v  = rdy ? ifb.in_valid : 4'h0;
            e.d  = 64'(ifb.in_data);
            e.sd = rdy & ifb.in_set_done;
            qb.push_back(e);
        end
    end

    // Count rising edges of the flush pulses.
    always @(negedge clk) begin
        if (ifa.out_fl_res && !fl_prev_a) pulses_a++;
        if (ifb.out_fl_res && !fl_prev_b) pulses_b++;
        fl_prev_a = ifa.out_fl_res;
        fl_prev_b = ifb.out_fl_res;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete set on dut_a; extras adds a second set-done during COUNT
    // (c=5) and an all-valid beat offered during FLUSH (c=12).
    task automatic run_set_a(input bit extras);
        int t0;
        t0 = cyc;
        blk_a_lo = t0 + 12;
        blk_a_hi = t0 + 14;
        for (int c = 0; c < 17; c++) begin
            ifa.in_set_done = (c == 0) || (extras && c == 5);
            ifa.in_valid    = (extras && c == 12) ? 4'hF : 4'h0;
            @(negedge clk);
            check_val("a_fl_res", 64'(ifa.out_fl_res), 64'(c == 12));
            check_val("a_busy", 64'(ifa.busy), 64'(c >= 2 && c <= 14));
            if (extras && c == 13) begin
                check_val("a_stalled_beat_dropped", 64'(ifa.out_valid), 64'(4'h0));
`ifdef BRIDGE_STATUS_EN
                check_val("a_err_set", 64'(ifa.err), 64'(1'b1));
`endif
            end
            next_cycle();
        end
        ifa.in_set_done = 1'b0;
        ifa.in_valid    = 4'h0;
    endtask

    task automatic run_set_b();
        int t0;
        t0 = cyc;
        blk_b_lo = t0 + 2;
        blk_b_hi = t0 + 4;
        for (int c = 0; c < 8; c++) begin
            ifb.in_set_done = (c == 0);
            @(negedge clk);
            check_val("b_fl_res", 64'(ifb.out_fl_res), 64'(c >= 2 && c <= 4));
            check_val("b_busy", 64'(ifb.busy), 64'(c >= 2 && c <= 4));
            next_cycle();
        end
        ifb.in_set_done = 1'b0;
    endtask

    initial begin
        res = 1'b1;
        ifa.in_valid = 4'h0; ifa.in_data = 64'h0; ifa.in_set_done = 1'b0; ifa.dnn_ready = 1'b1;
        ifb.in_valid = 4'h0; ifb.in_data = 64'h0; ifb.in_set_done = 1'b0; ifb.dnn_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        // Reset state.
        @(negedge clk);
        check_val("rst_a_valid", 64'(ifa.out_valid), 64'(4'h0));
        check_val("rst_a_data", 64'(ifa.out_data), 64'h0);
        check_val("rst_a_fl_res", 64'(ifa.out_fl_res), 64'(1'b0));
        check_val("rst_a_busy", 64'(ifa.busy), 64'(1'b0));
        check_val("rst_b_busy", 64'(ifb.busy), 64'(1'b0));
        check_val("rst_b_fl_res", 64'(ifb.out_fl_res), 64'(1'b0));
`ifdef BRIDGE_STATUS_EN
        check_val("rst_a_sets_done", 64'(ifa.sets_done), 64'(8'd0));
        check_val("rst_a_err", 64'(ifa.err), 64'(1'b0));
`endif
        next_cycle();

        // Bit-order example from both valid orders.
        ifa.in_valid = 4'b0001; ifa.in_data = {32'hA, 32'hB};
        ifb.in_valid = 4'b0001; ifb.in_data = {32'hA, 32'hB};
        next_cycle();
        ifa.in_valid = 4'h0; ifb.in_valid = 4'h0;
        @(negedge clk);
        check_val("a_reversed_valid", 64'(ifa.out_valid), 64'(4'b1000));
        check_val("a_data_ab", 64'(ifa.out_data), {32'hA, 32'hB});
        check_val("b_plain_valid", 64'(ifb.out_valid), 64'(4'b0001));
        next_cycle();

        // Random beats with random DNN back-pressure (scoreboard checks them).
        for (int i = 0; i < 40; i++) begin
            ifa.in_valid  = 4'($urandom);
            ifa.in_data   = {$urandom, $urandom};
            ifa.dnn_ready = ($urandom_range(0, 3) != 0);
            ifb.in_valid  = 4'($urandom);
            ifb.in_data   = {$urandom, $urandom};
            ifb.dnn_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        ifa.in_valid = 4'h0; ifa.dnn_ready = 1'b1;
        ifb.in_valid = 4'h0; ifb.dnn_ready = 1'b1;
        ifa.in_data  = 64'h1234_5678_9ABC_DEF0;
        next_cycle();

        // Three back-to-back sets on dut_a, the first with protocol abuse.
        run_set_a(1'b1);
        run_set_a(1'b0);
        run_set_a(1'b0);
        check_val("a_pulse_count", 64'(pulses_a), 64'(3));
`ifdef BRIDGE_STATUS_EN
        check_val("a_sets_done", 64'(ifa.sets_done), 64'(8'd3));
        check_val("a_err_sticky", 64'(ifa.err), 64'(1'b1));
`endif

        // Zero-delay, three-cycle pulse, no guard on dut_b.
        run_set_b();
        check_val("b_pulse_count", 64'(pulses_b), 64'(1));

        // Asynchronous reset in the middle of a flush pulse.
        blk_a_lo = cyc + 12;
        blk_a_hi = cyc + 14;
        for (int c = 0; c < 12; c++) begin
            ifa.in_set_done = (c == 0);
            next_cycle();
        end
        @(negedge clk);
        check_val("a_fl_res_before_reset", 64'(ifa.out_fl_res), 64'(1'b1));
        #2 res = 1'b1;
        #1;
        check_val("async_a_fl_res", 64'(ifa.out_fl_res), 64'(1'b0));
        check_val("async_a_busy", 64'(ifa.busy), 64'(1'b0));
        check_val("async_a_data", 64'(ifa.out_data), 64'h0);
        check_val("async_a_ready", 64'(ifa.out_ready), 64'(1'b1));
`ifdef BRIDGE_STATUS_EN
        check_val("async_a_err", 64'(ifa.err), 64'(1'b0));
        check_val("async_a_sets_done", 64'(ifa.sets_done), 64'(8'd0));
`endif
        blk_a_lo = -100;
        blk_a_hi = -100;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        repeat (4) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_dnn_bridge.md
Name: conv_dnn_bridge

Overview:
- Parametrised handoff stage between the conv/pooling pipeline and the dense (DNN) network.
- Registers the conv per-kernel valid vector, PE data and set-done through a configurable-depth pipeline, with optional valid bit-order reversal.
- After each completed image set, runs a flush FSM that issues a timed flush-reset pulse to the DNN and back-pressures the conv side until the DNN is re-armed.

Parameters:
BitSize, 32, width of each PE data word
NumPE, 2, number of parallel data lanes (conv processing elements)
NumK, 4, number of kernel channels; width of valid vector
PipeStages, 1, register stages on valid/data/set_done; legal range 1..8
FlushDelay, 10, cycles from set-done at pipeline output to flush pulse (default = NumK + 6 nerves)
FlushLen, 1, flush pulse length in cycles; legal range 1..15
GuardCycles, 2, stall cycles after pulse before returning to IDLE; 0 legal
ReverseValid, 1, 1 = out_valid[i] = valid[NumK-1-i]; 0 = pass-through order

Ports:
clk  in  1  clock
res  in  1  asynchronous active-high reset
in_valid  in  NumK  per-kernel valid from conv stage
in_data  in  NumPE*BitSize  PE data words, packed [NumPE-1:0][BitSize-1:0]
in_set_done  in  1  single-cycle end-of-set strobe from conv stage
dnn_ready  in  1  DNN can accept data
out_ready  out  1  conv stage may issue data
out_valid  out  NumK  valid to DNN (order per ReverseValid)
out_data  out  NumPE*BitSize  data to DNN
out_set_done  out  1  delayed set-done
out_fl_res  out  1  active-high flush/reset pulse to DNN
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (res high, async): all pipeline registers 0; FSM = IDLE; counters 0; out_valid = 0, out_data = 0, out_set_done = 0, out_fl_res = 0, busy = 0. out_ready = dnn_ready (combinational).
- Pipeline: valid/data/set_done delayed exactly PipeStages cycles. Reversal is applied at the input of stage 1.
- Input masking: a beat is accepted only when out_ready is high in that cycle. Otherwise in_valid and in_set_done enter stage 1 as 0. in_data is always captured.
- out_ready = dnn_ready AND (state == IDLE OR state == COUNT).
- FSM (registered):
  - IDLE: out_set_done == 1 -> COUNT, cnt <= 1. If FlushDelay == 0, go directly to FLUSH instead.
  - COUNT: cnt++ each cycle. When cnt == FlushDelay -> FLUSH.
  - FLUSH: out_fl_res = 1 (registered, asserted from the first FLUSH cycle) for exactly FlushLen cycles. Then -> GUARD, or -> IDLE if GuardCycles == 0.
  - GUARD: hold GuardCycles cycles -> IDLE.
- Counter width: $clog2(max(FlushDelay, FlushLen, GuardCycles) + 1) + 1. It never wraps, because the FSM exits at the terminal count.
- Simultaneous events:
  - out_set_done while in COUNT/FLUSH/GUARD is ignored by the FSM; the counter is not restarted.
  - out_set_done in the same cycle the FSM returns to IDLE is not seen; it must arrive while in IDLE.
- Pipeline contents keep shifting during FLUSH/GUARD. Beats already in flight still reach the DNN.
- Reset mid-operation: immediate return to the reset state. A pulse in progress is truncated.

Optional Feature:
- Macro: BRIDGE_STATUS_EN.
- Defined: adds output sets_done (8 bits) and output err (1 bit).
  - sets_done: saturating count of completed flush sequences (increments on FLUSH->next transition; saturates at 255).
  - err: sticky; set on in_valid != 0 or in_set_done while out_ready == 0, or on out_set_done while not in IDLE. Cleared only by res.
- Undefined: neither port exists and no status logic is generated. All other behaviour is identical.

Test Plan:
- Reset release with dnn_ready = 1 -> all outputs 0, out_ready = 1, busy = 0; res asserted asynchronously mid-cycle clears the outputs immediately.
- PipeStages = 1, ReverseValid = 1, in_valid = 4'b0001, in_data = {32'hA, 32'hB} -> next cycle out_valid = 4'b1000, out_data = {32'hA, 32'hB}. With ReverseValid = 0 -> out_valid = 4'b0001.
- Defaults, in_set_done at cycle 0:
  - out_set_done at cycle 1.
  - out_fl_res high only at cycle 12.
  - out_ready low cycles 12–14, high at cycle 15; busy high cycles 2–14.
- FlushDelay = 0, FlushLen = 3, GuardCycles = 0, set_done at cycle 0 -> out_fl_res high cycles 2–4; out_ready high again at cycle 5.
- in_valid = 4'hF presented while out_ready = 0 (FLUSH) -> out_valid stays 0 for that beat; with BRIDGE_STATUS_EN, err = 1 and stays 1 until res.
- Three back-to-back sets, each sent after the prior flush completes, with BRIDGE_STATUS_EN -> sets_done = 3 and exactly three out_fl_res pulses. A second set_done during COUNT -> pulse count unchanged and err = 1.
